// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, and multi-cycle
// results queue in a small FIFO that drains into idle write slots, with WAW kill on conflict.
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p_we,
    input  logic [ADDRESS_WIDTH-1:0]      p_ad,
    input  logic [DATA_WIDTH-1:0]         p_wd,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [ADDRESS_WIDTH-1:0]      s_ad,
    input  logic [DATA_WIDTH-1:0]         s_wd,
    output logic                          WE3,
    output logic [ADDRESS_WIDTH-1:0]      AD3,
    output logic [DATA_WIDTH-1:0]         WD3,
    output logic [2**ADDRESS_WIDTH-1:0]   pending,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2**ADDRESS_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic                     live_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] ad_q   [DEPTH];
    logic [DATA_WIDTH-1:0]    wd_q   [DEPTH];
    logic [PW-1:0]            wptr;
    logic [PW-1:0]            rptr;
    logic [CW-1:0]            cnt;

    logic prim_live;
    logic empty;
    logic head_live;
    logic pop;
    logic pop_wr;
    logic accept;
    logic enq;
    logic [NREG-1:0] pend;

    // A slot holds a queued entry when its distance from the read pointer is below the occupancy.
    function automatic logic occupied(input logic [PW-1:0] slot,
                                      input logic [PW-1:0] rd,
                                      input logic [CW-1:0] n);
        logic [PW-1:0] off;
        off = slot - rd;
        return ({1'b0, off} < n);
    endfunction

    assign prim_live = p_we && (p_ad != '0);
    assign empty     = (cnt == '0);
    assign head_live = !empty && live_q[rptr];
    // Killed heads leave in any cycle; live heads only when the pipeline is not writing.
    assign pop       = !empty && (!live_q[rptr] || !prim_live);
    assign pop_wr    = head_live && !prim_live;
    assign s_ready   = !rst && (cnt < FULL);
    assign accept    = s_valid && s_ready;
    // Register 0 results and results already overwritten by this cycle's primary are dropped.
    assign enq       = accept && (s_ad != '0) && !(prim_live && (s_ad == p_ad));

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            case ({enq, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Older queued results to the register the pipeline is writing now must never land.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) live_q[i] <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (prim_live && (ad_q[i] == p_ad)) live_q[i] <= 1'b0;
            end
            if (enq) live_q[wptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ad_q[wptr] <= s_ad;
            wd_q[wptr] <= s_wd;
        end
    end

    // Output register stage: primary, then live FIFO head, else idle with address/data held.
    always_ff @(posedge clk) begin
        if (rst) begin
            WE3 <= 1'b0;
            AD3 <= '0;
            WD3 <= '0;
        end else if (prim_live) begin
            WE3 <= 1'b1;
            AD3 <= p_ad;
            WD3 <= p_wd;
        end else if (pop_wr) begin
            WE3 <= 1'b1;
            AD3 <= ad_q[rptr];
            WD3 <= wd_q[rptr];
        end else begin
            WE3 <= 1'b0;
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && occupied(PW'(i), rptr, cnt)) pend[ad_q[i]] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    assign pending = pend;
    assign count   = cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// compared each cycle against a queue-based model of the write-port rules.
module tb_regfile_wb_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          p_we;
    logic [AW-1:0] p_ad;
    logic [DW-1:0] p_wd;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] s_ad;
    logic [DW-1:0] s_wd;
    logic          WE3;
    logic [AW-1:0] AD3;
    logic [DW-1:0] WD3;
    logic [2**AW-1:0] pending;
    logic [$clog2(DEPTH):0] count;

    regfile_wb_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .p_we   (p_we),
        .p_ad   (p_ad),
        .p_wd   (p_wd),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_ad   (s_ad),
        .s_wd   (s_wd),
        .WE3    (WE3),
        .AD3    (AD3),
        .WD3    (WD3),
        .pending(pending),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          live;
        bit [AW-1:0] ad;
        bit [DW-1:0] wd;
    } ent_t;

    ent_t          q[$];
    bit            ewe;
    bit [AW-1:0]   ead;
    bit [DW-1:0]   ewd;
    bit            last_acc;
    int            n_assert = 0;
    int            n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit pwe, input logic [AW-1:0] pad, input logic [DW-1:0] pwd,
                        input bit sv, input logic [AW-1:0] sad, input logic [DW-1:0] swd);
        bit          ready;
        bit          prim;
        bit          acc;
        bit          wrote;
        ent_t        h;
        bit [2**AW-1:0] epend;
        rst = r; p_we = pwe; p_ad = pad; p_wd = pwd;
        s_valid = sv; s_ad = sad; s_wd = swd;
        #1;
        ready = !r && (q.size() < DEPTH);
        chk("s_ready", s_ready, ready);
        acc = sv && ready;
        last_acc = acc;
        if (r) begin
            q.delete();
            ewe = 0; ead = 0; ewd = 0;
        end else begin
            prim  = pwe && (pad != 0);
            wrote = 0;
            if (q.size() > 0) begin
                if (!q[0].live) void'(q.pop_front());
                else if (!prim) begin
                    h = q.pop_front();
                    wrote = 1;
                end
            end
            if (prim) begin
                ewe = 1; ead = pad; ewd = pwd;
            end else if (wrote) begin
                ewe = 1; ead = h.ad; ewd = h.wd;
            end else begin
                ewe = 0;
            end
            if (prim) foreach (q[i]) if (q[i].ad == pad) q[i].live = 0;
            if (acc && (sad != 0) && !(prim && (sad == pad))) q.push_back('{1'b1, sad, swd});
        end
        @(posedge clk);
        #1;
        epend = '0;
        foreach (q[i]) if (q[i].live) epend[q[i].ad] = 1'b1;
        chk("WE3", WE3, ewe);
        chk("AD3", AD3, ead);
        chk("WD3", WD3, ewd);
        chk("count", count, q.size());
        chk("pending", pending, epend);
    endtask

    initial begin
        bit          rr, pw, sv;
        logic [AW-1:0] pa, sa;
        logic [DW-1:0] pd, sd;

        rst = 1; p_we = 0; p_ad = 0; p_wd = 0; s_valid = 0; s_ad = 0; s_wd = 0;
        last_acc = 0;
        ewe = 0; ead = 0; ewd = 0;

        // reset with both producers active
        step(1, 1, 5'd4, 32'h1234, 1, 5'd6, 32'h5678);
        step(1, 1, 5'd4, 32'h1234, 1, 5'd6, 32'h5678);
        chk("rst_we", WE3, 0);
        chk("rst_cnt", count, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // primary passthrough
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        chk("pt_we", WE3, 1);
        chk("pt_ad", AD3, 5);
        chk("pt_wd", WD3, 32'hDEADBEEF);
        step(0, 1, 5'd0, 32'h0BAD0BAD, 0, 0, 0);
        chk("pt_r0", WE3, 0);

        // secondary drain under contention
        step(0, 1, 5'd1, 32'h101, 1, 5'd7, 32'h11);
        step(0, 1, 5'd2, 32'h102, 1, 5'd8, 32'h22);
        step(0, 1, 5'd3, 32'h103, 0, 0, 0);
        chk("cont_cnt", count, 2);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drain1_wd", WD3, 32'h11);
        chk("drain1_p8", pending[8], 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drain2_wd", WD3, 32'h22);
        step(0, 0, 0, 0, 0, 0, 0);

        // full FIFO and backpressure
        for (int i = 0; i < 4; i++) step(0, 1, 5'd20, 32'h200 + i, 1, 5'(10 + i), 32'h300 + i);
        chk("full_cnt", count, 4);
        chk("full_rdy", s_ready, 0);
        step(0, 1, 5'd20, 32'h299, 1, 5'd14, 32'h55);
        chk("held_acc", last_acc, 0);
        step(0, 0, 0, 0, 1, 5'd14, 32'h55);
        step(0, 0, 0, 0, 1, 5'd14, 32'h55);
        chk("held_taken", last_acc, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0);

        // kill of a queued entry and of a same-cycle secondary
        step(0, 1, 5'd1, 32'h1, 1, 5'd9, 32'hAA);
        chk("kill_p9_set", pending[9], 1);
        step(0, 1, 5'd9, 32'hBB, 0, 0, 0);
        chk("kill_wd", WD3, 32'hBB);
        chk("kill_p9_clr", pending[9], 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("kill_silent", WE3, 0);
        step(0, 1, 5'd9, 32'hCC, 1, 5'd9, 32'hDD);
        chk("same_cyc_cnt", count, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // wrap-around with the pipeline idle
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 1, 5'((i % 31) + 1), $urandom);
            chk("wrap_cnt_le1", (count <= 1), 1);
        end
        step(0, 0, 0, 0, 0, 0, 0);

        // random traffic, producer holds its values while stalled
        sv = 0; sa = 0; sd = 0;
        for (int c = 0; c < 1500; c++) begin
            rr = ($urandom_range(0, 99) == 0);
            pw = ($urandom_range(0, 99) < 45);
            pa = 5'($urandom_range(0, 7));
            pd = $urandom;
            if (!(sv && !last_acc)) begin
                sv = ($urandom_range(0, 99) < 60);
                sa = 5'($urandom_range(0, 7));
                sd = $urandom;
            end
            step(rr, pw, pa, pd, sv, sa, sd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-side initiator for the 32x32 register file: merges two result producers into the single write port (WE3/AD3/WD3). The in-order pipeline writeback always has priority and never stalls. A multi-cycle unit (mul/div, load miss) hands results over a valid/ready handshake into a small FIFO that drains in cycles when the pipeline does not write. The block also exports a pending-write mask for the hazard unit.

Parameters:
ADDRESS_WIDTH, 5, register address width (2**ADDRESS_WIDTH registers)
DATA_WIDTH, 32, register data width
DEPTH, 4, secondary FIFO entries; power of two, >=2

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
p_we  input  1  pipeline writeback enable
p_ad  input  ADDRESS_WIDTH  pipeline destination register
p_wd  input  DATA_WIDTH  pipeline writeback data
s_valid  input  1  multi-cycle unit result valid
s_ready  output  1  FIFO can accept a secondary result
s_ad  input  ADDRESS_WIDTH  secondary destination register
s_wd  input  DATA_WIDTH  secondary result data
WE3  output  1  register file write enable (registered)
AD3  output  ADDRESS_WIDTH  register file write address (registered)
WD3  output  DATA_WIDTH  register file write data (registered)
pending  output  2**ADDRESS_WIDTH  bit r set while a live FIFO entry targets register r
count  output  $clog2(DEPTH)+1  FIFO occupancy, including killed entries

Behaviour:
- Reset (rst high at a clock edge): WE3=0, AD3=0, WD3=0, FIFO empty, count=0, pending=0. s_ready=0 while rst is high.
- Reset mid-operation discards all queued entries. No write is issued in the cycle after reset.
- s_ready = !rst && (count < DEPTH), driven combinationally from registered state. A pop in the same cycle does not raise s_ready when the FIFO is full.
- Handshake: a transfer occurs when s_valid && s_ready at a clock edge. s_ad/s_wd are sampled on that edge. The producer holds its values while s_valid && !s_ready.
- Primary is live when p_we && p_ad != 0. A primary write with p_ad == 0 is ignored and does not block draining.
- Secondary with s_ad == 0 is accepted (handshake completes) and discarded; it is not enqueued.
- FIFO entry = {live bit, ad, wd}. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Output register update, evaluated each edge in this priority order:
  1. Primary live: WE3=1, AD3=p_ad, WD3=p_wd. Primary latency is 1 cycle.
  2. Else, FIFO non-empty with live head: pop; WE3=1, AD3/WD3 from the head.
  3. Else: WE3=0. AD3/WD3 hold their previous values.
- A killed (non-live) head is popped silently in any cycle, including cycles where the primary writes. That pop produces no write.
- Secondary minimum latency: accepted at edge N, written at edge N+1 (WE3 high after N+1) if the FIFO was empty and the primary is idle at N+1.
- Kill rule (WAW ordering): secondary results are older than the concurrent primary write. When a primary live write to register r occurs:
  - Every FIFO entry with ad==r loses its live bit.
  - A secondary accepted in the same cycle with s_ad==r is dropped rather than enqueued.
- Simultaneous enqueue and pop are allowed; count is unchanged in that case.
- pending[r] = OR over occupied slots of (live && ad==r). It is computed from registered state. pending[0] is always 0.
- count increments on enqueue, decrements on any pop (live or killed), and never exceeds DEPTH.

Test Plan:
- Reset check: hold rst 2 cycles with p_we=1, s_valid=1 -> WE3=0, count=0, s_ready=0 during reset. s_ready=1 the cycle after rst falls.
- Primary passthrough: p_we=1, p_ad=5, p_wd=0xDEADBEEF at edge N -> after N: WE3=1, AD3=5, WD3=0xDEADBEEF. With p_ad=0 -> WE3=0.
- Secondary drain under contention: enqueue ad=7/0x11, ad=8/0x22 while primary writes 3 cycles -> no secondary write. Then pipeline idle -> writes 7:0x11 then 8:0x22 on consecutive cycles; count goes 2->1->0. pending bits 7 and 8 clear in order.
- Full/backpressure: 4 accepts with primary busy -> count=4, s_ready=0. A 5th s_valid is held. After the first pop, s_ready=1 and the held entry is accepted.
- Kill: queue ad=9/0xAA, then primary writes ad=9/0xBB -> WE3 writes 0xBB. The entry is popped silently, no 0xAA write ever issued, and pending[9] clears the cycle after the primary write. Same-cycle s_ad=9 with primary ad=9 -> accepted, never written.
- Wrap-around: 10 back-to-back secondary results with the pipeline idle -> all 10 written in order with correct data, count never above 1.
